// File: rtl/video_scanout.sv
// rtl/video_scanout.sv - raster timing generator and RGB565 framebuffer scanout
// Places an FB_WIDTH x FB_HEIGHT window in the active raster; 3-cycle aligned video pipeline.
module video_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int FB_WIDTH   = 128,
  parameter int FB_HEIGHT  = 128,
  parameter int WIN_X      = 0,
  parameter int WIN_Y      = 0
) (
  input  logic        clk_pix,
  input  logic        reset_n_i,
  input  logic        flip_req_i,
  input  logic [23:0] front_base_i,
  input  logic [23:0] border_rgb_i,
  input  logic        clear_status_i,
  output logic        stream_start_frame_o,
  output logic [23:0] stream_base_address_o,
  output logic        stream_ena_o,
  input  logic [15:0] stream_data_i,
  input  logic        stream_preloading_i,
  input  logic        stream_err_underflow_i,
  output logic        vga_hsync_o,
  output logic        vga_vsync_o,
  output logic        vga_de_o,
  output logic [7:0]  vga_r_o,
  output logic [7:0]  vga_g_o,
  output logic [7:0]  vga_b_o,
  output logic        flip_done_o,
  output logic        underflow_o,
  output logic        late_preload_o,
  output logic [15:0] frame_count_o
);
  localparam int CW = 16;
  localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_PRE  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] WX     = CW'(WIN_X);
  localparam logic [CW-1:0] WY     = CW'(WIN_Y);
  localparam logic [CW-1:0] FBW    = CW'(FB_WIDTH);
  localparam logic [CW-1:0] FBH    = CW'(FB_HEIGHT);

  logic [CW-1:0] h, v, hx, vy;
  logic          active, in_window, hs_on, vs_on, update_edge, start_edge;
  logic          pending_valid, armed, flip_applied;
  logic [23:0]   pending_base;
  logic          act_d1, act_d2, win_d2, hs_d1, hs_d2, vs_d1, vs_d2;

  always_comb begin
    hx          = h - WX;
    vy          = v - WY;
    active      = (h < H_ACT) && (v < V_ACT);
    in_window   = active && (hx < FBW) && (vy < FBH);
    hs_on       = (h >= HS_BEG) && (h < HS_END);
    vs_on       = (v >= VS_BEG) && (v < VS_END);
    update_edge = (h == H_LAST) && (v == V_PRE);
    start_edge  = (h == '0) && (v == V_ACT);
  end

  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + CW'(1);
    end else begin
      h <= h + CW'(1);
    end
  end

  // A request landing on the update edge itself stays pending for the next frame.
  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pending_valid         <= 1'b0;
      pending_base          <= '0;
      stream_base_address_o <= '0;
      flip_applied          <= 1'b0;
      stream_start_frame_o  <= 1'b0;
      flip_done_o           <= 1'b0;
      frame_count_o         <= '0;
      armed                 <= 1'b0;
    end else begin
      if (update_edge) begin
        flip_applied <= pending_valid;
        if (pending_valid) stream_base_address_o <= pending_base;
      end
      if (flip_req_i) begin
        pending_valid <= 1'b1;
        pending_base  <= front_base_i;
      end else if (update_edge) begin
        pending_valid <= 1'b0;
      end
      stream_start_frame_o <= start_edge;
      flip_done_o          <= start_edge && flip_applied;
      if (start_edge) begin
        frame_count_o <= frame_count_o + 16'd1;
        armed         <= 1'b1;
      end
    end
  end

  // Stage 1 registers the enable, stage 2 meets the returned word, stage 3 drives the encoder.
  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stream_ena_o <= 1'b0;
      act_d1       <= 1'b0;
      hs_d1        <= 1'b0;
      vs_d1        <= 1'b0;
      act_d2       <= 1'b0;
      win_d2       <= 1'b0;
      hs_d2        <= 1'b0;
      vs_d2        <= 1'b0;
      vga_de_o     <= 1'b0;
      vga_hsync_o  <= ~H_SYNC_POL;
      vga_vsync_o  <= ~V_SYNC_POL;
      vga_r_o      <= '0;
      vga_g_o      <= '0;
      vga_b_o      <= '0;
    end else begin
      stream_ena_o <= armed && in_window;
      act_d1       <= active;
      hs_d1        <= hs_on;
      vs_d1        <= vs_on;
      act_d2       <= act_d1;
      win_d2       <= stream_ena_o;
      hs_d2        <= hs_d1;
      vs_d2        <= vs_d1;
      vga_de_o     <= act_d2;
      vga_hsync_o  <= hs_d2 ? H_SYNC_POL : ~H_SYNC_POL;
      vga_vsync_o  <= vs_d2 ? V_SYNC_POL : ~V_SYNC_POL;
      if (win_d2) begin
        vga_r_o <= {stream_data_i[15:11], stream_data_i[15:13]};
        vga_g_o <= {stream_data_i[10:5], stream_data_i[10:9]};
        vga_b_o <= {stream_data_i[4:0], stream_data_i[4:2]};
      end else if (act_d2) begin
        {vga_r_o, vga_g_o, vga_b_o} <= border_rgb_i;
      end else begin
        {vga_r_o, vga_g_o, vga_b_o} <= '0;
      end
    end
  end

  // Sticky status: a set in the same cycle as a clear wins.
  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      underflow_o    <= 1'b0;
      late_preload_o <= 1'b0;
    end else begin
      underflow_o    <= stream_err_underflow_i || (underflow_o && !clear_status_i);
      late_preload_o <= (stream_preloading_i && stream_ena_o) || (late_preload_o && !clear_status_i);
    end
  end
endmodule

// File: tb/tb_video_scanout.sv
// tb/tb_video_scanout.sv - randomized scoreboard bench for video_scanout
module tb_video_scanout;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int FW = 4, FH = 2, WX = 2, WY = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int T0 = VA * HT + 1;

  logic        clk_pix = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        flip_req_i = 1'b0;
  logic [23:0] front_base_i = '0;
  logic [23:0] border_rgb_i = '0;
  logic        clear_status_i = 1'b0;
  logic        stream_start_frame_o;
  logic [23:0] stream_base_address_o;
  logic        stream_ena_o;
  logic [15:0] stream_data_i = '0;
  logic        stream_preloading_i = 1'b0;
  logic        stream_err_underflow_i = 1'b0;
  logic        vga_hsync_o, vga_vsync_o, vga_de_o;
  logic [7:0]  vga_r_o, vga_g_o, vga_b_o;
  logic        flip_done_o, underflow_o, late_preload_o;
  logic [15:0] frame_count_o;

  always #5 clk_pix = ~clk_pix;

  video_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
    .FB_WIDTH(FW), .FB_HEIGHT(FH), .WIN_X(WX), .WIN_Y(WY)
  ) dut (
    .clk_pix(clk_pix), .reset_n_i(reset_n_i), .flip_req_i(flip_req_i),
    .front_base_i(front_base_i), .border_rgb_i(border_rgb_i), .clear_status_i(clear_status_i),
    .stream_start_frame_o(stream_start_frame_o), .stream_base_address_o(stream_base_address_o),
    .stream_ena_o(stream_ena_o), .stream_data_i(stream_data_i),
    .stream_preloading_i(stream_preloading_i), .stream_err_underflow_i(stream_err_underflow_i),
    .vga_hsync_o(vga_hsync_o), .vga_vsync_o(vga_vsync_o), .vga_de_o(vga_de_o),
    .vga_r_o(vga_r_o), .vga_g_o(vga_g_o), .vga_b_o(vga_b_o),
    .flip_done_o(flip_done_o), .underflow_o(underflow_o), .late_preload_o(late_preload_o),
    .frame_count_o(frame_count_o)
  );

  typedef struct {
    int          due;
    logic        ena, start, fdone, under, late, hs, vs, de;
    logic [23:0] base, rgb;
    logic [15:0] fc;
  } rec_t;

  rec_t        sb[$];
  rec_t        r;
  int          cyc = -100;
  int          tests = 0, fails = 0;
  int          ena_cnt = 0;
  bit          seen_start = 0;
  logic [15:0] pats [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};

  logic        pend_v, flip_app, under_m, late_m;
  logic [23:0] pend_b, act_b;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int hpos(int t); return t % HT; endfunction
  function automatic int vpos(int t); return (t / HT) % VT; endfunction
  function automatic bit win(int t);
    return t >= 0 && hpos(t) >= WX && hpos(t) < WX + FW && vpos(t) >= WY && vpos(t) < WY + FH;
  endfunction
  function automatic bit armed_win(int t); return t >= T0 && win(t); endfunction
  function automatic bit is_start(int t); return hpos(t) == 1 && vpos(t) == VA; endfunction
  function automatic logic [15:0] frames(int t);
    return (t < T0) ? 16'd0 : 16'(1 + (t - T0) / FRAME);
  endfunction
  function automatic logic [23:0] conv(logic [15:0] d);
    int rr, gg, bb;
    rr = int'(d) >> 11;
    gg = (int'(d) >> 5) & 63;
    bb = int'(d) & 31;
    return {8'(rr * 8 + rr / 4), 8'(gg * 4 + gg / 16), 8'(bb * 8 + bb / 4)};
  endfunction

  task automatic model_reset();
    pend_v = 0; flip_app = 0; under_m = 0; late_m = 0; pend_b = '0; act_b = '0;
  endtask

  task automatic run(int n, bit dir);
    rec_t e;
    int p;
    bit upd, fl, er, cl, pr;
    logic [23:0] fb, bd;
    logic [15:0] dt;
    for (int c = 0; c < n; c++) begin
      fl = 0;
      fb = 24'($urandom);
      er = $urandom_range(0, 39) == 0;
      cl = $urandom_range(0, 29) == 0;
      pr = $urandom_range(0, 9) == 0;
      dt = ($urandom_range(0, 1) == 1) ? pats[$urandom_range(0, 3)] : 16'($urandom);
      bd = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h123456;
      if (dir) begin
        if (c < 60) begin
          er = (c == 20) || (c == 40);
          cl = (c == 30) || (c == 40);
        end
        if (c == 2 * HT + 5) begin fl = 1; fb = 24'h004000; end
        else if (c == FRAME + VA * HT - 1) begin fl = 1; fb = 24'h00ABCD; end
        else if (c >= 3 * FRAME) fl = $urandom_range(0, 149) == 0;
      end else begin
        fl = $urandom_range(0, 149) == 0;
      end
      flip_req_i = fl; front_base_i = fb; stream_err_underflow_i = er;
      clear_status_i = cl; stream_preloading_i = pr; stream_data_i = dt; border_rgb_i = bd;

      late_m  = (pr && armed_win(c - 1)) || (late_m && !cl);
      under_m = er || (under_m && !cl);
      upd = hpos(c + 1) == 0 && vpos(c + 1) == VA;
      if (upd) begin
        flip_app = pend_v;
        if (pend_v) act_b = pend_b;
      end
      if (fl) begin pend_v = 1; pend_b = fb; end
      else if (upd) pend_v = 0;

      e.due   = c + 1;
      e.ena   = armed_win(c);
      e.start = is_start(c + 1);
      e.fdone = is_start(c + 1) && flip_app;
      e.fc    = frames(c + 1);
      e.base  = act_b;
      e.under = under_m;
      e.late  = late_m;
      p = c - 2;
      if (p >= 0 && hpos(p) < HA && vpos(p) < VA) begin
        e.de  = 1;
        e.rgb = armed_win(p) ? conv(dt) : bd;
      end else begin
        e.de  = 0;
        e.rgb = '0;
      end
      e.hs = !(p >= 0 && hpos(p) >= HA + HF && hpos(p) < HA + HF + HS);
      e.vs = !(p >= 0 && vpos(p) >= VA + VF && vpos(p) < VA + VF + VS);
      sb.push_back(e);
      @(posedge clk_pix); #1;
      cyc = c + 1;
    end
  endtask

  always @(negedge clk_pix) begin
    if (!reset_n_i) begin
      seen_start = 0;
      ena_cnt = 0;
    end else begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        r = sb.pop_front();
        check("stream_ena", 32'(stream_ena_o), 32'(r.ena));
        check("start_frame", 32'(stream_start_frame_o), 32'(r.start));
        check("flip_done", 32'(flip_done_o), 32'(r.fdone));
        check("frame_count", 32'(frame_count_o), 32'(r.fc));
        check("base_address", 32'(stream_base_address_o), 32'(r.base));
        check("underflow", 32'(underflow_o), 32'(r.under));
        check("late_preload", 32'(late_preload_o), 32'(r.late));
        check("hsync", 32'(vga_hsync_o), 32'(r.hs));
        check("vsync", 32'(vga_vsync_o), 32'(r.vs));
        check("de", 32'(vga_de_o), 32'(r.de));
        check("rgb", 32'({vga_r_o, vga_g_o, vga_b_o}), 32'(r.rgb));
      end
      if (stream_start_frame_o) begin
        if (seen_start) check("enables_per_frame", 32'(ena_cnt), 32'(FW * FH));
        seen_start = 1;
        ena_cnt = 0;
      end
      if (stream_ena_o) ena_cnt++;
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk_pix);
    #1;
    check("rst_ena", 32'(stream_ena_o), 32'd0);
    check("rst_start", 32'(stream_start_frame_o), 32'd0);
    check("rst_base", 32'(stream_base_address_o), 32'd0);
    check("rst_de", 32'(vga_de_o), 32'd0);
    check("rst_rgb", 32'({vga_r_o, vga_g_o, vga_b_o}), 32'd0);
    check("rst_hsync", 32'(vga_hsync_o), 32'd1);
    check("rst_vsync", 32'(vga_vsync_o), 32'd1);
    check("rst_flip_done", 32'(flip_done_o), 32'd0);
    check("rst_underflow", 32'(underflow_o), 32'd0);
    check("rst_late", 32'(late_preload_o), 32'd0);
    check("rst_frame_count", 32'(frame_count_o), 32'd0);

    reset_n_i = 1'b1;
    cyc = 0;
    run(6 * FRAME + HT + 3, 1'b1);

    reset_n_i = 1'b0;
    #1;
    check("midrst_ena", 32'(stream_ena_o), 32'd0);
    check("midrst_de", 32'(vga_de_o), 32'd0);
    check("midrst_frame_count", 32'(frame_count_o), 32'd0);
    check("midrst_base", 32'(stream_base_address_o), 32'd0);
    check("midrst_underflow", 32'(underflow_o), 32'd0);
    sb.delete();
    cyc = -100;
    flip_req_i = 0; stream_err_underflow_i = 0; clear_status_i = 0; stream_preloading_i = 0;
    repeat (2) @(posedge clk_pix);
    #1;
    model_reset();
    reset_n_i = 1'b1;
    cyc = 0;
    run(4 * FRAME, 1'b0);

    @(negedge clk_pix); #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
